// File: rtl/dbg_spi_pkg.sv
// Shared definitions for the SPI debug slave.
// Command codes, frame widths and FSM state encoding.
package dbg_spi_pkg;

    localparam int CMD_W = 8;

    localparam logic [CMD_W-1:0] CMD_WRITE = 8'h02;
    localparam logic [CMD_W-1:0] CMD_READ  = 8'h03;
    localparam logic [CMD_W-1:0] CMD_CTRL  = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_CTRL,
        ST_IGNORE
    } dbg_spi_state_t;

endpackage

// File: rtl/dbg_spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin.
// Reset value is a parameter so idle pin levels survive reset.
module dbg_spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the pin through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= {STAGES{RST_VAL}};
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/dbg_spi_slave.sv
// SPI mode-0 debug slave: oversampled on the nano clock, decodes
// write / read / halt-control frames into debug memory strobes.
module dbg_spi_slave
    import dbg_spi_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_nano_clk,
    input  logic              i_nano_rst,
    input  logic              i_dbg_spi_en_n,
    input  logic              i_dbg_spi_sclk,
    input  logic              i_dbg_spi_mosi,
    output logic              o_dbg_spi_miso,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_dbg_halt,
    output logic              o_dbg_busy
);

    localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAXW   = (CMD_W > MAX_AD) ? CMD_W : MAX_AD;
    localparam int CNT_W  = $clog2(MAXW + 1);
    localparam int SH_W   = MAXW - 1;

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic en_n_s, sclk_s, mosi_s;
    logic en_n_p, sclk_p;

    dbg_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
        .clk (i_nano_clk),
        .rst (i_nano_rst),
        .d   (i_dbg_spi_en_n),
        .q   (en_n_s)
    );

    dbg_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (i_nano_clk),
        .rst (i_nano_rst),
        .d   (i_dbg_spi_sclk),
        .q   (sclk_s)
    );

    dbg_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (i_nano_clk),
        .rst (i_nano_rst),
        .d   (i_dbg_spi_mosi),
        .q   (mosi_s)
    );

    dbg_spi_state_t    state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [SH_W-1:0]   rx;
    logic [DATA_W-1:0] tx;
    logic              tx_live;
    logic              rd_cmd;
    logic              cap;

    logic rise, fall, en_fall;
    logic cmd_done, addr_done, wr_done, ctrl_done, rd_done;
    logic shift_rx, cnt_en;
    logic [CMD_W-1:0]  cmd_word;
    logic [ADDR_W-1:0] addr_word;
    logic [DATA_W-1:0] data_word;

    // Edge history of the synchronized chip select and clock
    always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
        if (i_nano_rst) begin
            en_n_p <= 1'b1;
            sclk_p <= 1'b0;
        end else begin
            en_n_p <= en_n_s;
            sclk_p <= sclk_s;
        end
    end

    assign rise    = sclk_s & ~sclk_p & ~en_n_s;
    assign fall    = ~sclk_s & sclk_p & ~en_n_s;
    assign en_fall = en_n_p & ~en_n_s;

    assign cmd_word  = {rx[CMD_W-2:0], mosi_s};
    assign addr_word = {rx[ADDR_W-2:0], mosi_s};
    assign data_word = {rx[DATA_W-2:0], mosi_s};

    // State register
    always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
        if (i_nano_rst) state <= ST_IDLE;
        else            state <= state_n;
    end

    // Next state and per-cycle frame events
    always_comb begin
        state_n   = state;
        cmd_done  = 1'b0;
        addr_done = 1'b0;
        wr_done   = 1'b0;
        ctrl_done = 1'b0;
        rd_done   = 1'b0;
        shift_rx  = 1'b0;
        cnt_en    = 1'b0;
        if (en_n_s) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (en_fall) state_n = ST_CMD;
                end
                ST_CMD: begin
                    shift_rx = rise;
                    cnt_en   = rise;
                    if (rise && cnt == CMD_LAST) begin
                        cmd_done = 1'b1;
                        case (cmd_word)
                            CMD_WRITE, CMD_READ: state_n = ST_ADDR;
                            CMD_CTRL:            state_n = ST_CTRL;
                            default:             state_n = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    shift_rx = rise;
                    cnt_en   = rise;
                    if (rise && cnt == ADDR_LAST) begin
                        addr_done = 1'b1;
                        state_n   = rd_cmd ? ST_RDATA : ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    shift_rx = rise;
                    cnt_en   = rise;
                    if (rise && cnt == DATA_LAST) begin
                        wr_done = 1'b1;
                        state_n = ST_IGNORE;
                    end
                end
                ST_CTRL: begin
                    shift_rx = rise;
                    cnt_en   = rise;
                    if (rise && cnt == DATA_LAST) begin
                        ctrl_done = 1'b1;
                        state_n   = ST_IGNORE;
                    end
                end
                ST_RDATA: begin
                    cnt_en = rise & tx_live;
                    if (rise && tx_live && cnt == DATA_LAST) begin
                        rd_done = 1'b1;
                        state_n = ST_IGNORE;
                    end
                end
                ST_IGNORE: begin
                    state_n = ST_IGNORE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Shift registers, bit counter and memory/halt outputs
    always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
        if (i_nano_rst) begin
            cnt         <= '0;
            rx          <= '0;
            tx          <= '0;
            tx_live     <= 1'b0;
            rd_cmd      <= 1'b0;
            cap         <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_we    <= 1'b0;
            o_mem_re    <= 1'b0;
            o_dbg_halt  <= 1'b0;
        end else begin
            o_mem_we <= wr_done;
            o_mem_re <= addr_done & rd_cmd;
            cap      <= o_mem_re;

            if (state_n != state) cnt <= '0;
            else if (cnt_en)      cnt <= cnt + 1'b1;

            if (shift_rx) rx <= {rx[SH_W-2:0], mosi_s};

            if (cmd_done) rd_cmd <= (cmd_word == CMD_READ);

            if (addr_done) begin
                o_mem_addr <= addr_word;
                tx         <= '0;
                tx_live    <= 1'b0;
            end

            if (wr_done)   o_mem_wdata <= data_word;
            if (ctrl_done) o_dbg_halt  <= mosi_s;

            // Master samples on rise, so only falls after a rise advance MISO
            if (cap && state == ST_RDATA) begin
                tx      <= i_mem_rdata;
                tx_live <= 1'b1;
            end else if (fall && state == ST_RDATA && tx_live && cnt != '0) begin
                tx <= {tx[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign o_dbg_spi_miso = (state == ST_RDATA) & tx[DATA_W-1];
    assign o_dbg_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_dbg_spi_slave.sv
// Directed bench for the SPI debug slave: acts as SPI master
// and as a one-cycle-latency debug memory.
module tb_dbg_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_n, sclk, mosi;
    logic       miso;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, mem_re, halt, busy;

    int checks   = 0;
    int failures = 0;

    int         we_cnt = 0;
    int         re_cnt = 0;
    int         miso_bad = 0;
    logic       watch_miso = 1'b0;
    logic [7:0] we_addr, we_data, re_addr;
    logic [7:0] rd_val = 8'h00;

    dbg_spi_slave #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_nano_clk     (clk),
        .i_nano_rst     (rst),
        .i_dbg_spi_en_n (en_n),
        .i_dbg_spi_sclk (sclk),
        .i_dbg_spi_mosi (mosi),
        .o_dbg_spi_miso (miso),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_we       (mem_we),
        .o_mem_re       (mem_re),
        .i_mem_rdata    (mem_rdata),
        .o_dbg_halt     (halt),
        .o_dbg_busy     (busy)
    );

    always #5 clk = ~clk;

    // Debug memory: data valid exactly one cycle after the read strobe
    always @(posedge clk) mem_rdata <= mem_re ? rd_val : 8'hFF;

    // Strobe monitor sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = mem_addr;
            we_data = mem_wdata;
        end
        if (mem_re) begin
            re_cnt  = re_cnt + 1;
            re_addr = mem_addr;
        end
        if (watch_miso && miso) miso_bad = miso_bad + 1;
    end

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        repeat (8) @(posedge clk);
        #1;
        r    = miso;
        sclk = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], x);
            r[i] = x;
        end
    endtask

    task automatic frame_begin();
        en_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic frame_end();
        repeat (8) @(posedge clk);
        #1;
        en_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({miso, mem_we, mem_re, halt, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {miso, mem_we, mem_re, halt, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_bus got=%h want=0000", {mem_addr, mem_wdata});
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        logic [7:0] r;
        int we0 = we_cnt;
        int re0 = re_cnt;
        frame_begin();
        spi_byte(8'h02, r);
        spi_byte(8'h3C, r);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL wr_busy got=%b want=1", busy);
        end
        spi_byte(8'hA7, r);
        frame_end();
        checks++;
        if (we_cnt - we0 != 1) begin
            failures++;
            $display("FAIL wr_pulses got=%0d want=1", we_cnt - we0);
        end
        checks++;
        if ({we_addr, we_data} !== 16'h3CA7) begin
            failures++;
            $display("FAIL wr_addr_data got=%h want=3ca7", {we_addr, we_data});
        end
        checks++;
        if (re_cnt != re0) begin
            failures++;
            $display("FAIL wr_no_re got=%0d want=0", re_cnt - re0);
        end
    endtask

    task automatic test_read();
        logic [7:0] r;
        int re0 = re_cnt;
        int we0 = we_cnt;
        rd_val = 8'h5A;
        frame_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h10, r);
        spi_byte(8'h00, r);
        frame_end();
        checks++;
        if (re_cnt - re0 != 1) begin
            failures++;
            $display("FAIL rd_pulses got=%0d want=1", re_cnt - re0);
        end
        checks++;
        if (re_addr !== 8'h10) begin
            failures++;
            $display("FAIL rd_addr got=%h want=10", re_addr);
        end
        checks++;
        if (r !== 8'h5A) begin
            failures++;
            $display("FAIL rd_miso got=%h want=5a", r);
        end
        checks++;
        if (we_cnt != we0) begin
            failures++;
            $display("FAIL rd_no_we got=%0d want=0", we_cnt - we0);
        end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        logic       x;
        int we0 = we_cnt;
        frame_begin();
        spi_byte(8'h02, r);
        spi_byte(8'h3C, r);
        spi_bit(1'b1, x);
        spi_bit(1'b0, x);
        spi_bit(1'b1, x);
        en_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy got=%b want=0", busy);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (we_cnt != we0) begin
            failures++;
            $display("FAIL abort_no_we got=%0d want=0", we_cnt - we0);
        end
        frame_begin();
        spi_byte(8'h02, r);
        spi_byte(8'h55, r);
        spi_byte(8'hC3, r);
        frame_end();
        checks++;
        if (we_cnt - we0 != 1 || {we_addr, we_data} !== 16'h55C3) begin
            failures++;
            $display("FAIL abort_recover got=%0d/%h want=1/55c3",
                     we_cnt - we0, {we_addr, we_data});
        end
    endtask

    task automatic test_unknown();
        logic [7:0] r;
        int we0 = we_cnt;
        int re0 = re_cnt;
        miso_bad   = 0;
        watch_miso = 1'b1;
        frame_begin();
        spi_byte(8'h7F, r);
        spi_byte(8'h3C, r);
        spi_byte(8'hA7, r);
        frame_end();
        watch_miso = 1'b0;
        checks++;
        if (we_cnt != we0 || re_cnt != re0) begin
            failures++;
            $display("FAIL unk_strobes got=%0d/%0d want=0/0",
                     we_cnt - we0, re_cnt - re0);
        end
        checks++;
        if (halt !== 1'b0) begin
            failures++;
            $display("FAIL unk_halt got=%b want=0", halt);
        end
        checks++;
        if (miso_bad != 0) begin
            failures++;
            $display("FAIL unk_miso got=%0d want=0", miso_bad);
        end
    endtask

    task automatic test_ctrl();
        logic [7:0] r;
        logic       x;
        frame_begin();
        spi_byte(8'h04, r);
        spi_byte(8'h01, r);
        frame_end();
        checks++;
        if (halt !== 1'b1) begin
            failures++;
            $display("FAIL ctrl_set got=%b want=1", halt);
        end
        frame_begin();
        spi_byte(8'h04, r);
        spi_byte(8'h00, r);
        frame_end();
        checks++;
        if (halt !== 1'b0) begin
            failures++;
            $display("FAIL ctrl_clr got=%b want=0", halt);
        end
        frame_begin();
        spi_byte(8'h04, r);
        spi_byte(8'h01, r);
        frame_end();
        frame_begin();
        spi_byte(8'h04, r);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, x);
        frame_end();
        checks++;
        if (halt !== 1'b1) begin
            failures++;
            $display("FAIL ctrl_abort got=%b want=1", halt);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] r;
        logic       x;
        int we0;
        frame_begin();
        spi_byte(8'h02, r);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, x);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({miso, mem_we, mem_re, halt, busy} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_ctrl got=%b want=00000",
                     {miso, mem_we, mem_re, halt, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_bus got=%h want=0000", {mem_addr, mem_wdata});
        end
        en_n = 1'b1;
        sclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        we0 = we_cnt;
        frame_begin();
        spi_byte(8'h02, r);
        spi_byte(8'h81, r);
        spi_byte(8'h7E, r);
        frame_end();
        checks++;
        if (we_cnt - we0 != 1 || {we_addr, we_data} !== 16'h817E) begin
            failures++;
            $display("FAIL rstmid_recover got=%0d/%h want=1/817e",
                     we_cnt - we0, {we_addr, we_data});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_unknown();
        test_ctrl();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
